data_mem_unit: RTL and testbench
================================

# data_mem_unit

Data-memory stage slave for the five-stage core's MEM port. It takes the core's MEM-stage address, store data, func3 and write enable, and returns load data combinationally for capture into the MEM/WB register. It holds word-organised RAM with byte-lane stores and load extension, plus a small memory-mapped block: a free-running timer, a timer compare register, a status register and a scratch register. It also detects misaligned stores.

## Interface
- DEPTH_WORDS, 1024, RAM size in 32-bit words; RAM occupies bytes 0 .. DEPTH_WORDS*4-1.
- MMIO_BASE, 32'h0001_0000, base of the 16-byte register block; must be 16-byte aligned.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- addr  in  32  byte address, driven from ALU result in MEM stage.
- data_in  in  32  store data, driven from forwarded rs2 in MEM stage.
- func3  in  3  access size/sign, from instruction bits [14:12] in MEM stage.
- memW_en  in  1  store strobe for this cycle.
- data_out  out  32  load data, combinational, feeds MEM/WB.
- timer_irq  out  1  registered timer-pending flag.
- misalign_err  out  1  sticky misaligned-store flag (STATUS bit 1).

## Operation
- Address decode:
  - RAM when addr < DEPTH_WORDS*4.
  - MMIO when addr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped: reads return 0 and writes are ignored.
- RAM stores, committed on the clock edge when memW_en=1 and rst=0:
  - func3 000 (SB): write byte lane addr[1:0] with data_in[7:0].
  - func3 001 (SH): write halfword lane addr[1] with data_in[15:0]; misaligned if addr[0]=1.
  - func3 010 (SW): write the full word; misaligned if addr[1:0]≠0.
  - Any other func3: no write and no error.
- Misaligned store handling:
  - The write is suppressed.
  - STATUS[1] is set.
  - STATUS[15:8] increments, saturating at 255.
- RAM loads: combinational from the word at addr[31:2].
  - 000 LB: sign-extend byte lane addr[1:0].
  - 001 LH: sign-extend halfword lane addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte lane addr[1:0].
  - 101 LHU: zero-extend halfword lane addr[1].
  - 011, 110, 111: full word.
  - Misaligned loads are not flagged; they return the lane selected by the rules above.
- MMIO registers (offset = addr[3:2]; word access only):
  - Writes require func3=010; other func3 values are ignored without error.
  - Reads return the full register regardless of func3.
  - 0x0 MTIME: increments by 1 every cycle and wraps FFFF_FFFF→0. A write loads data_in; the increment is suppressed in that cycle.
  - 0x4 MTIMECMP: read/write.
  - 0x8 STATUS:
    - bit0 = timer_irq (read-only).
    - bit1 = misalign sticky.
    - [15:8] = misaligned-store count.
    - Other bits read 0.
    - Writing 1 to bit1 clears both bit1 and the count. Writing 0 to bit1 has no effect.
  - 0xC SCRATCH: plain read/write.
- timer_irq is registered each cycle from (MTIME ≥ MTIMECMP), using an unsigned 32-bit compare on current register values.

## Timing
- Reset values:
  - MTIME = 0, MTIMECMP = FFFF_FFFF, STATUS fields = 0, SCRATCH = 0.
  - timer_irq = 0, misalign_err = 0.
  - RAM contents are not reset; they are undefined until written.
- Reset priority:
  - rst takes priority over everything.
  - A store presented in a cycle with rst=1 is dropped, for RAM and MMIO alike.
  - Reset mid-run returns all registers to their reset values on that edge.
- Load latency is 0 cycles: data_out is valid in the same cycle as addr/func3.
- Store latency is 1 edge:
  - A load to the same address in the same cycle as the store returns the old contents.
  - A load in the next cycle returns the new contents.
- MTIME write of value V at edge n: MTIME reads V during cycle n+1 and V+1 during cycle n+2.
- timer_irq lags the compare condition by one cycle.
  - Example: with MTIMECMP = 5 after reset, MTIME reads 5 in the 6th cycle after reset release, and timer_irq rises one cycle later.
- misalign_err rises in the cycle after the offending store edge.
- STATUS clear and the flag deassertion take effect on the same edge.

## Test plan
- **Store/load lanes.** SW 0x8899AABB to RAM 0x10, then:
  - LB 0x11 → 0xFFFFFFAA; LBU 0x11 → 0x000000AA.
  - LH 0x12 → 0xFFFF8899; LHU 0x12 → 0x00008899; LW 0x10 → 0x8899AABB.
- **Byte merge.** SB 0x55 to 0x13 over the previous word → LW 0x10 = 0x5599AABB. In the same cycle as the SB, a LW returns 0x8899AABB.
- **Misaligned stores.** SW to 0x21, then SH to 0x23:
  - RAM words 0x20/0x24 are unchanged.
  - misalign_err = 1 and STATUS reads 0x0000_0202.
  - Writing STATUS = 0x2 → next cycle STATUS = 0 and misalign_err = 0.
  - 300 misaligned stores → count reads 0xFF.
- **Timer.** Write MTIMECMP = 20, then MTIME = 10:
  - MTIME reads 10 in the next cycle.
  - timer_irq rises exactly 11 cycles after the MTIME write edge.
  - Writing MTIME = FFFF_FFFF → MTIME reads 0 two cycles later and timer_irq falls.
- **Decode.** SW to 0x0002_0000 is ignored; LW from 0x0002_0000 reads 0. SCRATCH at MMIO_BASE+0xC round-trips 0xDEADBEEF. SB to MMIO is ignored.
- **Reset.** Assert rst for one cycle during an active SW to SCRATCH:
  - SCRATCH = 0, MTIME = 0, MTIMECMP = FFFF_FFFF, timer_irq = 0 afterwards.
  - A RAM word written before reset retains its value.

Source files
------------

// File: rtl/data_mem_unit_if.sv
// MEM-stage data port between the core and the data memory unit.
// Core side is the master; the memory unit is the slave.
interface data_mem_unit_if;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [2:0]  func3;
  logic        memW_en;
  logic [31:0] data_out;
  logic        timer_irq;
  logic        misalign_err;

  modport master (
    output addr, data_in, func3, memW_en,
    input  data_out, timer_irq, misalign_err
  );

  modport slave (
    input  addr, data_in, func3, memW_en,
    output data_out, timer_irq, misalign_err
  );
endinterface

// File: rtl/data_mem_unit.sv
// Data memory: byte-lane RAM, load extension, timer/status MMIO block
// and sticky misaligned-store detection.
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
  input logic            clk,
  input logic            rst,
  data_mem_unit_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_LIM = 33'(DEPTH_WORDS) << 2;

  logic [31:0] ram_q [DEPTH_WORDS];

  logic [31:0] mtime_q, mtime_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] scr_q, scr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        stk_q, stk_d;
  logic        irq_q, irq_d;

  logic          is_ram, is_mmio, mmio_we, mis;
  logic [1:0]    off;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wdat, word, ram_rd, mmio_rd;
  logic [7:0]    lb;
  logic [15:0]   lh;

  assign is_ram  = {1'b0, bus.addr} < RAM_LIM;
  assign is_mmio = bus.addr[31:4] == MMIO_BASE[31:4];
  assign off     = bus.addr[3:2];
  assign widx    = bus.addr[AW+1:2];
  assign mmio_we = bus.memW_en && is_mmio && bus.func3 == 3'b010;

  always_comb begin
    be   = 4'b0000;
    mis  = 1'b0;
    wdat = bus.data_in;
    if (bus.memW_en && is_ram) begin
      case (bus.func3)
        3'b000: begin
          be   = 4'b0001 << bus.addr[1:0];
          wdat = {4{bus.data_in[7:0]}};
        end
        3'b001: begin
          if (bus.addr[0]) mis = 1'b1;
          else be = bus.addr[1] ? 4'b1100 : 4'b0011;
          wdat = {2{bus.data_in[15:0]}};
        end
        3'b010: begin
          if (bus.addr[1:0] != 2'b00) mis = 1'b1;
          else be = 4'b1111;
        end
        default: ;
      endcase
    end
  end

  // RAM has no reset; stores are dropped while rst is high
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram_q[widx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_comb begin
    word = ram_q[widx];
    lb   = word[8*bus.addr[1:0] +: 8];
    lh   = bus.addr[1] ? word[31:16] : word[15:0];
    case (bus.func3)
      3'b000:  ram_rd = {{24{lb[7]}}, lb};
      3'b001:  ram_rd = {{16{lh[15]}}, lh};
      3'b100:  ram_rd = {24'h0, lb};
      3'b101:  ram_rd = {16'h0, lh};
      default: ram_rd = word;
    endcase
  end

  always_comb begin
    case (off)
      2'd0:    mmio_rd = mtime_q;
      2'd1:    mmio_rd = cmp_q;
      2'd2:    mmio_rd = {16'h0, cnt_q, 6'b0, stk_q, irq_q};
      default: mmio_rd = scr_q;
    endcase
  end

  assign bus.data_out     = is_ram  ? ram_rd :
                            is_mmio ? mmio_rd : 32'h0;
  assign bus.timer_irq    = irq_q;
  assign bus.misalign_err = stk_q;

  always_comb begin
    mtime_d = mtime_q + 32'd1;
    cmp_d   = cmp_q;
    scr_d   = scr_q;
    stk_d   = stk_q;
    cnt_d   = cnt_q;
    irq_d   = mtime_q >= cmp_q;
    if (mmio_we) begin
      case (off)
        2'd0: mtime_d = bus.data_in;
        2'd1: cmp_d   = bus.data_in;
        2'd2: begin
          if (bus.data_in[1]) begin
            stk_d = 1'b0;
            cnt_d = 8'h00;
          end
        end
        default: scr_d = bus.data_in;
      endcase
    end
    if (mis) begin
      stk_d = 1'b1;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      scr_q   <= 32'h0;
      stk_q   <= 1'b0;
      cnt_q   <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      scr_q   <= scr_d;
      stk_q   <= stk_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end
endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: directed scenarios with fixed
// expectations, then random traffic against a byte-level model.
module tb_data_mem_unit;
  localparam logic [31:0] MB = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst;
  data_mem_unit_if bus ();

  data_mem_unit #(
    .DEPTH_WORDS(1024),
    .MMIO_BASE  (MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    int          kind;
    int          id;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  // reference model state
  logic [7:0]  mmem [int unsigned];
  logic [31:0] m_time, m_cmp, m_scr;
  bit          m_stk, m_irq;
  int          m_cnt;

  function automatic logic [7:0] rb(logic [31:0] a);
    if (mmem.exists(a)) return mmem[a];
    return 8'hxx;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a, logic [2:0] f);
    logic [31:0] b, h;
    logic [7:0]  bv;
    logic [15:0] hv;
    logic [31:0] w;
    if (a < 32'd4096) begin
      b  = a & ~32'd3;
      h  = a & ~32'd1;
      w  = {rb(b + 3), rb(b + 2), rb(b + 1), rb(b)};
      bv = rb(a);
      hv = {rb(h + 1), rb(h)};
      case (f)
        3'd0: return {{24{bv[7]}}, bv};
        3'd1: return {{16{hv[15]}}, hv};
        3'd4: return {24'h0, bv};
        3'd5: return {16'h0, hv};
        default: return w;
      endcase
    end
    if ((a & 32'hFFFF_FFF0) == MB) begin
      case (a[3:2])
        2'd0: return m_time;
        2'd1: return m_cmp;
        2'd2: return {16'h0, 8'(m_cnt), 6'b0, m_stk, m_irq};
        default: return m_scr;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic m_step(logic [31:0] a, logic [31:0] d,
                        logic [2:0] f, bit we, bit r);
    logic [31:0] t_n;
    bit irq_n, mis;
    if (r) begin
      m_time = 0; m_cmp = 32'hFFFF_FFFF; m_scr = 0;
      m_stk = 0; m_cnt = 0; m_irq = 0;
      return;
    end
    irq_n = m_time >= m_cmp;
    t_n = m_time + 1;
    mis = 0;
    if (we && a < 32'd4096) begin
      if (f == 3'd0) mmem[a] = d[7:0];
      else if (f == 3'd1) begin
        if (a[0]) mis = 1;
        else begin mmem[a] = d[7:0]; mmem[a + 1] = d[15:8]; end
      end else if (f == 3'd2) begin
        if (a[1:0] != 0) mis = 1;
        else for (int i = 0; i < 4; i++) mmem[a + i] = d[8*i +: 8];
      end
    end else if (we && f == 3'd2 && (a & 32'hFFFF_FFF0) == MB) begin
      case (a[3:2])
        2'd0: t_n = d;
        2'd1: m_cmp = d;
        2'd2: if (d[1]) begin m_stk = 0; m_cnt = 0; end
        default: m_scr = d;
      endcase
    end
    if (mis) begin
      m_stk = 1;
      if (m_cnt < 255) m_cnt++;
    end
    m_time = t_n;
    m_irq = irq_n;
  endtask

  task automatic drv(logic [31:0] a, logic [31:0] d,
                     logic [2:0] f, bit we, bit r);
    bus.addr = a; bus.data_in = d; bus.func3 = f;
    bus.memW_en = we; rst = r;
  endtask

  task automatic push(int k, logic [31:0] e, int id);
    exp_t x;
    x.exp = e; x.kind = k; x.id = id;
    sbq.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    m_step(bus.addr, bus.data_in, bus.func3, bus.memW_en, rst);
    #1;
  endtask

  task automatic st(logic [31:0] a, logic [31:0] d, logic [2:0] f);
    drv(a, d, f, 1'b1, 1'b0);
    tick();
  endtask

  task automatic ld(logic [31:0] a, logic [2:0] f,
                    logic [31:0] e, int id);
    drv(a, 32'h0, f, 1'b0, 1'b0);
    push(0, e, id);
    tick();
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        0: act = bus.data_out;
        1: act = {31'h0, bus.timer_irq};
        default: act = {31'h0, bus.misalign_err};
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL chk%0d kind%0d got=%h want=%h",
                 e.id, e.kind, act, e.exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0]  f;
    bit          we, r;
    int          c;
    drv(0, 0, 3'd2, 0, 1);
    tick();
    tick();
    // reset state
    drv(MB, 0, 3'd2, 0, 0);
    push(0, 32'h0, 1); push(1, 0, 2); push(2, 0, 3);
    tick();
    ld(MB + 4, 3'd2, 32'hFFFF_FFFF, 4);
    ld(MB + 8, 3'd2, 32'h0, 5);
    ld(MB + 12, 3'd2, 32'h0, 6);
    // timer
    st(MB + 4, 32'd20, 3'd2);
    st(MB, 32'd10, 3'd2);
    for (int k = 1; k <= 12; k++) begin
      drv(MB, 0, 3'd2, 0, 0);
      push(0, 32'd9 + 32'(k), 100 + k);
      push(1, {31'h0, k == 12}, 120 + k);
      tick();
    end
    st(MB, 32'hFFFF_FFFF, 3'd2);
    drv(MB, 0, 3'd2, 0, 0);
    push(0, 32'hFFFF_FFFF, 10); push(1, 1, 11);
    tick();
    drv(MB, 0, 3'd2, 0, 0);
    push(0, 32'h0, 12); push(1, 1, 13);
    tick();
    drv(MB, 0, 3'd2, 0, 0);
    push(0, 32'h1, 14); push(1, 0, 15);
    tick();
    // reset during a SCRATCH store
    st(32'h40, 32'hCAFE_F00D, 3'd2);
    st(MB + 12, 32'h1111_2222, 3'd2);
    st(MB + 4, 32'h5, 3'd2);
    drv(MB + 12, 32'h3333_4444, 3'd2, 1, 1);
    tick();
    drv(MB, 0, 3'd2, 0, 0);
    push(0, 32'h0, 20); push(1, 0, 21); push(2, 0, 22);
    tick();
    ld(MB + 4, 3'd2, 32'hFFFF_FFFF, 23);
    ld(MB + 12, 3'd2, 32'h0, 24);
    ld(32'h40, 3'd2, 32'hCAFE_F00D, 25);
    // lanes
    st(32'h10, 32'h8899_AABB, 3'd2);
    ld(32'h11, 3'd0, 32'hFFFF_FFAA, 30);
    ld(32'h11, 3'd4, 32'h0000_00AA, 31);
    ld(32'h12, 3'd1, 32'hFFFF_8899, 32);
    ld(32'h12, 3'd5, 32'h0000_8899, 33);
    ld(32'h10, 3'd2, 32'h8899_AABB, 34);
    // byte merge; same-cycle load sees old byte
    drv(32'h13, 32'h55, 3'd0, 1, 0);
    push(0, 32'hFFFF_FF88, 35);
    tick();
    ld(32'h10, 3'd2, 32'h5599_AABB, 36);
    // misaligned stores
    st(32'h20, 32'h0102_0304, 3'd2);
    st(32'h24, 32'h0506_0708, 3'd2);
    st(32'h21, 32'hFFFF_FFFF, 3'd2);
    drv(32'h23, 32'hEEEE, 3'd1, 1, 0);
    push(2, 1, 40);
    tick();
    ld(32'h20, 3'd2, 32'h0102_0304, 41);
    ld(32'h24, 3'd2, 32'h0506_0708, 42);
    ld(MB + 8, 3'd2, 32'h0000_0202, 43);
    st(MB + 8, 32'h2, 3'd2);
    drv(MB + 8, 0, 3'd2, 0, 0);
    push(0, 32'h0, 44); push(2, 0, 45);
    tick();
    for (int i = 0; i < 300; i++) st(32'h21, 32'h0, 3'd2);
    drv(MB + 8, 0, 3'd2, 0, 0);
    push(0, 32'h0000_FF02, 46); push(2, 1, 47);
    tick();
    st(MB + 8, 32'h2, 3'd2);
    ld(MB + 8, 3'd2, 32'h0, 48);
    // decode
    st(32'h0, 32'hA5A5_A5A5, 3'd2);
    st(32'h0002_0000, 32'h1234_5678, 3'd2);
    ld(32'h0002_0000, 3'd2, 32'h0, 50);
    ld(32'h0, 3'd2, 32'hA5A5_A5A5, 51);
    st(MB + 12, 32'hDEAD_BEEF, 3'd2);
    ld(MB + 12, 3'd2, 32'hDEAD_BEEF, 52);
    st(MB + 12, 32'h11, 3'd0);
    ld(MB + 12, 3'd0, 32'hDEAD_BEEF, 53);
    // random traffic against the model
    for (int i = 0; i < 16; i++) st(32'h100 + 32'(4 * i), $urandom, 3'd2);
    for (int i = 0; i < 600; i++) begin
      c = $urandom_range(0, 99);
      if (c < 60) a = 32'h100 + $urandom_range(0, 63);
      else if (c < 85) a = MB + $urandom_range(0, 15);
      else if (c < 93) a = 32'h0002_0000 + $urandom_range(0, 15);
      else a = 32'h1000 + $urandom_range(0, 3);
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 40);
      f = 3'($urandom_range(0, 7));
      we = $urandom_range(0, 2) == 0;
      r = $urandom_range(0, 99) == 0;
      drv(a, d, f, we, r);
      push(0, m_read(a, f), 1000 + i);
      push(1, {31'h0, m_irq}, 2000 + i);
      push(2, {31'h0, m_stk}, 3000 + i);
      tick();
    end
    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
